// File: rtl/gate_truth_checker_if.sv
// Bus between the truth checker and whatever drives/observes it: run control,
// the stimulus vector toward the gate under test, the gate's response, and
// the run results.
interface gate_truth_checker_if #(
   parameter int N_IN  = 2,
   parameter int ERR_W = 4
);
   logic             start;
   logic [1:0]       func;
   logic [N_IN-1:0]  stim;
   logic             y_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [N_IN-1:0]  first_fail;
   logic             fail_valid;

   modport master (
      output start, func, y_in,
      input  stim, busy, done, pass, err_count, first_fail, fail_valid
   );

   modport slave (
      input  start, func, y_in,
      output stim, busy, done, pass, err_count, first_fail, fail_valid
   );
endinterface

// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table checker for a small combinational gate. Walks every
// input vector, lets the gate settle, samples its output and compares it to a
// selected reference function, keeping a saturating error count and the first
// failing vector.
module gate_truth_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 4
) (
   input logic                 clk,
   input logic                 rst,
   gate_truth_checker_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [N_IN-1:0]  VEC_LAST    = '1;
   localparam logic [N_IN-1:0]  VEC_ONE     = N_IN'(1);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

   logic [1:0]       state;
   logic [1:0]       func_q;
   logic [3:0]       settle_cnt;
   logic [N_IN-1:0]  stim;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [N_IN-1:0]  first_fail;
   logic             fail_valid;

   logic             expected;
   logic             mismatch;
   logic [ERR_W-1:0] err_next;

   // Reference truth function selected by the latched func code.
   function automatic logic ref_out(input logic [1:0] f, input logic [N_IN-1:0] v);
      case (f)
         2'b00:   ref_out = &v;
         2'b01:   ref_out = |v;
         2'b10:   ref_out = ^v;
         default: ref_out = ~&v;
      endcase
   endfunction

   // Error counter increment that sticks at all-ones.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      sat_inc = (c == ERR_MAX) ? c : c + ERR_ONE;
   endfunction

   // Compare the sampled gate output against the reference for the current vector.
   always_comb begin
      expected = ref_out(func_q, stim);
      mismatch = (bus.y_in != expected);
      err_next = mismatch ? sat_inc(err_count) : err_count;
   end

   // Run sequencer: IDLE -> (SETTLE -> SAMPLE) per vector -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         func_q     <= 2'b00;
         settle_cnt <= '0;
         stim       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  func_q     <= bus.func;
                  stim       <= '0;
                  settle_cnt <= '0;
                  err_count  <= '0;
                  pass       <= 1'b0;
                  first_fail <= '0;
                  fail_valid <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  first_fail <= stim;
                  fail_valid <= 1'b1;
               end
               // The last vector is checked before the run ends; stim never wraps.
               if (stim == VEC_LAST) begin
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= ST_DONE;
               end else begin
                  stim       <= stim + VEC_ONE;
                  settle_cnt <= '0;
                  state      <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.stim       = stim;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.pass       = pass;
   assign bus.err_count  = err_count;
   assign bus.first_fail = first_fail;
   assign bus.fail_valid = fail_valid;

endmodule
